// File: rtl/onehot_decoder_if.sv
// Code/handshake bundle between a code source and onehot_decoder.
// The source drives din/en; the decoder returns ready, the one-hot
// select, its valid flag, the drop flag and the accept counter.
interface onehot_decoder_if;
    logic [2:0] din;
    logic       en;
    logic       rdy;
    logic [7:0] y;
    logic       y_vld;
    logic       drop;
    logic [7:0] cnt;

    modport master (
        output din,
        output en,
        input  rdy,
        input  y,
        input  y_vld,
        input  drop,
        input  cnt
    );

    modport slave (
        input  din,
        input  en,
        output rdy,
        output y,
        output y_vld,
        output drop,
        output cnt
    );
endinterface

// File: rtl/onehot_decoder.sv
// Registered 3-to-8 one-hot decoder with a valid/ready handshake and a
// pulse stretcher. Each accepted code drives one bit of y for PULSE_LEN
// cycles, then the block idles for GAP_LEN cycles before it is ready again.
// Codes offered while busy are discarded and flagged on drop.
module onehot_decoder #(
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned GAP_LEN   = 1
) (
    input  logic             clk,
    input  logic             rst,
    onehot_decoder_if.slave  bus_io
);

    // Elaboration-time guard on the stretcher parameters.
    if (PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_bad_pulse_len
        $error("onehot_decoder: PULSE_LEN must be in 1..255");
    end
    if (GAP_LEN > 15) begin : g_bad_gap_len
        $error("onehot_decoder: GAP_LEN must be in 0..15");
    end

    // Timer reload values; the timer counts down to zero inclusive.
    localparam logic [7:0] PulseLast = 8'(PULSE_LEN - 1);
    localparam logic [7:0] GapLast   = (GAP_LEN == 0) ? 8'd0 : 8'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrive = 2'd1,
        StGap   = 2'd2
    } state_e;

    state_e     state_q;
    logic [7:0] timer_q;
    logic [7:0] y_q;
    logic       y_vld_q;
    logic       drop_q;
    logic [7:0] cnt_q;

    logic       rdy_w;
    logic       accept_w;
    logic [7:0] onehot_w;

    // Ready is a pure decode of state; accept and the decoded code feed the FSM.
    always_comb begin
        rdy_w    = (state_q == StIdle);
        accept_w = bus_io.en & rdy_w;
        onehot_w = 8'b0000_0001 << bus_io.din;
    end

    // Handshake FSM with registered outputs; reset dominates everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            timer_q <= 8'd0;
            y_q     <= 8'd0;
            y_vld_q <= 1'b0;
            drop_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            // An en seen while busy is lost; flag it for exactly the next cycle.
            drop_q <= bus_io.en & ~rdy_w;
            unique case (state_q)
                StIdle: begin
                    if (accept_w) begin
                        y_q     <= onehot_w;
                        y_vld_q <= 1'b1;
                        timer_q <= PulseLast;
                        cnt_q   <= cnt_q + 8'd1;
                        state_q <= StDrive;
                    end
                end
                StDrive: begin
                    if (timer_q != 8'd0) begin
                        timer_q <= timer_q - 8'd1;
                    end else begin
                        y_q     <= 8'd0;
                        y_vld_q <= 1'b0;
                        if (GAP_LEN == 0) begin
                            state_q <= StIdle;
                        end else begin
                            timer_q <= GapLast;
                            state_q <= StGap;
                        end
                    end
                end
                StGap: begin
                    if (timer_q != 8'd0) begin
                        timer_q <= timer_q - 8'd1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    timer_q <= 8'd0;
                    y_q     <= 8'd0;
                    y_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus_io.rdy   = rdy_w;
    assign bus_io.y     = y_q;
    assign bus_io.y_vld = y_vld_q;
    assign bus_io.drop  = drop_q;
    assign bus_io.cnt   = cnt_q;

endmodule

// File: tb/tb_onehot_decoder.sv
// Directed bench for onehot_decoder: three instances cover the default
// stretcher, PULSE_LEN=1/GAP_LEN=0 back-to-back traffic, and PULSE_LEN=8.
module tb_onehot_decoder;

    logic clk;
    logic rst_def;
    logic rst_b2b;
    logic rst_lng;

    int errors;
    int checks;

    onehot_decoder_if if_def ();
    onehot_decoder_if if_b2b ();
    onehot_decoder_if if_lng ();

    onehot_decoder #(.PULSE_LEN(4), .GAP_LEN(1)) u_def (
        .clk    (clk),
        .rst    (rst_def),
        .bus_io (if_def)
    );

    onehot_decoder #(.PULSE_LEN(1), .GAP_LEN(0)) u_b2b (
        .clk    (clk),
        .rst    (rst_b2b),
        .bus_io (if_b2b)
    );

    onehot_decoder #(.PULSE_LEN(8), .GAP_LEN(1)) u_lng (
        .clk    (clk),
        .rst    (rst_lng),
        .bus_io (if_lng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] din;
        logic [7:0] exp_y;
    } sweep_vec_t;

    typedef struct {
        logic       en;
        logic [2:0] din;
        logic [7:0] exp_y;
        logic       exp_drop;
        logic       exp_rdy;
        logic [7:0] exp_cnt;
    } cyc_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    sweep_vec_t sweep [8];
    cyc_vec_t   b2b [8];

    initial begin
        errors = 0;
        checks = 0;

        sweep[0] = '{3'd0, 8'h01};
        sweep[1] = '{3'd1, 8'h02};
        sweep[2] = '{3'd2, 8'h04};
        sweep[3] = '{3'd3, 8'h08};
        sweep[4] = '{3'd4, 8'h10};
        sweep[5] = '{3'd5, 8'h20};
        sweep[6] = '{3'd6, 8'h40};
        sweep[7] = '{3'd7, 8'h80};

        // Inputs applied before edge i, outputs expected just after edge i.
        b2b[0] = '{1'b1, 3'd3, 8'h08, 1'b0, 1'b0, 8'd1};
        b2b[1] = '{1'b1, 3'd3, 8'h00, 1'b1, 1'b1, 8'd1};
        b2b[2] = '{1'b1, 3'd6, 8'h40, 1'b0, 1'b0, 8'd2};
        b2b[3] = '{1'b1, 3'd6, 8'h00, 1'b1, 1'b1, 8'd2};
        b2b[4] = '{1'b1, 3'd3, 8'h08, 1'b0, 1'b0, 8'd3};
        b2b[5] = '{1'b1, 3'd3, 8'h00, 1'b1, 1'b1, 8'd3};
        b2b[6] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 8'd3};
        b2b[7] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 8'd3};

        // Reset held two cycles with en=1, din=5: nothing may be accepted.
        rst_def = 1'b1; rst_b2b = 1'b1; rst_lng = 1'b1;
        if_def.en = 1'b1; if_def.din = 3'd5;
        if_b2b.en = 1'b1; if_b2b.din = 3'd5;
        if_lng.en = 1'b1; if_lng.din = 3'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_y",     32'(if_def.y), 32'h00);
        chk("reset_y_vld", 32'(if_def.y_vld), 32'd0);
        chk("reset_cnt",   32'(if_def.cnt), 32'd0);
        chk("reset_rdy",   32'(if_def.rdy), 32'd1);
        chk("reset_drop",  32'(if_def.drop), 32'd0);
        chk("reset_b2b_cnt", 32'(if_b2b.cnt), 32'd0);
        chk("reset_lng_rdy", 32'(if_lng.rdy), 32'd1);
        rst_def = 1'b0; rst_b2b = 1'b0; rst_lng = 1'b0;
        if_def.en = 1'b0; if_b2b.en = 1'b0; if_lng.en = 1'b0;
        @(negedge clk);

        // Full sweep on the default instance.
        for (int i = 0; i < 8; i++) begin
            int w;
            w = 0;
            while (!if_def.rdy && w < 20) begin
                @(negedge clk);
                w++;
            end
            chk("sweep_rdy_wait", 32'(if_def.rdy), 32'd1);
            if_def.din = sweep[i].din;
            if_def.en  = 1'b1;
            @(posedge clk);
            #1 if_def.en = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                chk("sweep_y",     32'(if_def.y), 32'(sweep[i].exp_y));
                chk("sweep_y_vld", 32'(if_def.y_vld), 32'd1);
                chk("sweep_rdy_low", 32'(if_def.rdy), 32'd0);
                chk("sweep_drop",  32'(if_def.drop), 32'd0);
            end
            @(negedge clk);
            chk("sweep_y_off",   32'(if_def.y), 32'h00);
            chk("sweep_vld_off", 32'(if_def.y_vld), 32'd0);
            chk("sweep_gap_rdy", 32'(if_def.rdy), 32'd0);
            @(negedge clk);
            chk("sweep_rdy_back", 32'(if_def.rdy), 32'd1);
        end
        chk("sweep_cnt", 32'(if_def.cnt), 32'd8);

        // Back-to-back traffic with en held high.
        for (int i = 0; i < 8; i++) begin
            if_b2b.en  = b2b[i].en;
            if_b2b.din = b2b[i].din;
            @(negedge clk);
            chk("b2b_y",    32'(if_b2b.y), 32'(b2b[i].exp_y));
            chk("b2b_drop", 32'(if_b2b.drop), 32'(b2b[i].exp_drop));
            chk("b2b_rdy",  32'(if_b2b.rdy), 32'(b2b[i].exp_rdy));
            chk("b2b_cnt",  32'(if_b2b.cnt), 32'(b2b[i].exp_cnt));
        end

        // Drop and din change while busy on the default instance.
        if_def.din = 3'd2;
        if_def.en  = 1'b1;
        @(negedge clk);
        chk("busy_y0", 32'(if_def.y), 32'h04);
        if_def.din = 3'd7;
        @(negedge clk);
        chk("busy_y1",   32'(if_def.y), 32'h04);
        chk("busy_drop", 32'(if_def.drop), 32'd1);
        chk("busy_cnt",  32'(if_def.cnt), 32'd9);
        if_def.en = 1'b0;
        @(negedge clk);
        chk("busy_y2",        32'(if_def.y), 32'h04);
        chk("busy_drop_clear", 32'(if_def.drop), 32'd0);
        @(negedge clk);
        chk("busy_y3", 32'(if_def.y), 32'h04);
        @(negedge clk);
        chk("busy_y_off", 32'(if_def.y), 32'h00);
        chk("busy_cnt_end", 32'(if_def.cnt), 32'd9);

        // Reset in the middle of an 8-cycle pulse.
        if_lng.din = 3'd4;
        if_lng.en  = 1'b1;
        @(negedge clk);
        if_lng.en = 1'b0;
        chk("mid_y0", 32'(if_lng.y), 32'h10);
        @(negedge clk);
        @(negedge clk);
        chk("mid_y2", 32'(if_lng.y), 32'h10);
        rst_lng   = 1'b1;
        if_lng.en = 1'b1;
        @(negedge clk);
        chk("mid_rst_y",    32'(if_lng.y), 32'h00);
        chk("mid_rst_rdy",  32'(if_lng.rdy), 32'd1);
        chk("mid_rst_vld",  32'(if_lng.y_vld), 32'd0);
        chk("mid_rst_drop", 32'(if_lng.drop), 32'd0);
        chk("mid_rst_cnt",  32'(if_lng.cnt), 32'd0);
        rst_lng    = 1'b0;
        if_lng.din = 3'd1;
        @(negedge clk);
        if_lng.en = 1'b0;
        chk("mid_next_y",   32'(if_lng.y), 32'h02);
        chk("mid_next_cnt", 32'(if_lng.cnt), 32'd1);

        // Counter wrap: 257 accepts on the 2-cycle-per-code instance.
        rst_b2b   = 1'b1;
        if_b2b.en = 1'b0;
        @(negedge clk);
        rst_b2b    = 1'b0;
        if_b2b.din = 3'd0;
        if_b2b.en  = 1'b1;
        for (int n = 1; n <= 257; n++) begin
            @(negedge clk);
            if (n == 255) chk("wrap_cnt_255", 32'(if_b2b.cnt), 32'hFF);
            if (n == 256) chk("wrap_cnt_256", 32'(if_b2b.cnt), 32'h00);
            if (n == 257) begin
                chk("wrap_cnt_257", 32'(if_b2b.cnt), 32'h01);
                chk("wrap_y",       32'(if_b2b.y), 32'h01);
            end
            @(negedge clk);
        end
        if_b2b.en = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
